muldiv4_seq_divider: RTL



---
 rtl/muldiv4_seq_divider.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv4_seq_divider.sv
// muldiv4_seq_divider: sequential restoring divider producing one quotient bit per clock.
// Optional signed mode (truncating toward zero) is built when MULDIV4_SIGNED_DIV_EN is defined.
module muldiv4_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef MULDIV4_SIGNED_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remd_q, remd_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]        rem_sh;
    logic signed [WIDTH:0] trial;
    logic                  fit;
    logic [WIDTH-1:0]      rem_nx, quo_nx;
    logic [WIDTH-1:0]      dnd_mag, dvs_mag;

    // The partial remainder stays below the divisor, so the shifted value plus
    // a sign bit always fits in WIDTH+1 bits.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = $signed(rem_sh - {1'b0, dvs_q});
    assign fit    = ~trial[WIDTH];
    assign rem_nx = fit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], fit};

`ifdef MULDIV4_SIGNED_DIV_EN
    logic fix_q, fix_d;
    logic negq_q, negq_d;
    logic negr_q, negr_d;
    logic dnd_neg, dvs_neg;

    // Min-negative maps to itself, which is its correct unsigned magnitude.
    assign dnd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dnd_mag = dnd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign dnd_mag          = dividend;
    assign dvs_mag          = divisor;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
`ifdef MULDIV4_SIGNED_DIV_EN
        fix_d   = fix_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        remd_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        rem_d   = '0;
                        quo_d   = dnd_mag;
                        dvs_d   = dvs_mag;
`ifdef MULDIV4_SIGNED_DIV_EN
                        fix_d   = is_signed;
                        negq_d  = dnd_neg ^ dvs_neg;
                        negr_d  = dnd_neg;
`endif
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
`ifdef MULDIV4_SIGNED_DIV_EN
                    if (fix_q) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DONE;
                        quot_d  = quo_nx;
                        remd_d  = rem_nx;
                    end
`else
                    state_d = S_DONE;
                    quot_d  = quo_nx;
                    remd_d  = rem_nx;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef MULDIV4_SIGNED_DIV_EN
            // Quotient takes the XOR of operand signs, remainder follows the dividend.
            S_FIX: begin
                state_d = S_DONE;
                quot_d  = negq_q ? -quo_q : quo_q;
                remd_d  = negr_q ? -rem_q : rem_q;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef MULDIV4_SIGNED_DIV_EN
            fix_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV4_SIGNED_DIV_EN
            fix_q   <= fix_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

`ifdef MULDIV4_SIGNED_DIV_EN
    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
`else
    assign busy = (state_q == S_RUN);
`endif
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule
